// File: rtl/sram_port_arbiter_if.sv
// Request/response bundle between the two requesters and the SRAM port arbiter.
// The master side belongs to the requesters and the slave side to the arbiter.
interface sram_port_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 16
);
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_we;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [DW-1:0] req_wdata0;
  logic [DW-1:0] req_wdata1;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM macro between two requesters: zero-fills it after
// reset or on command, then grants round-robin with a fixed 3-cycle response latency.
module sram_port_arbiter #(
  parameter int AW = 7,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_start,
  output logic          busy,
  sram_port_arbiter_if.slave bus,
  output logic [AW-1:0] sram_a,
  output logic          sram_csb,
  output logic          sram_web,
  output logic          sram_oeb,
  output logic [DW-1:0] sram_i,
  input  logic [DW-1:0] sram_o
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;
  logic          prio;
  logic [1:0]    grant;
  logic          issue;
  logic          issue_port;
  logic          issue_we;
  logic [AW-1:0] issue_addr;
  logic [DW-1:0] issue_wdata;

  logic          vld_p0, vld_p1;
  logic          port_p0, port_p1;
  logic          rd_p0, rd_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Grants are only raised in RUN; a clear command lets this cycle's grant issue.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    grant       = 2'b00;
    case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == AW'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN: begin
        if (!rst) begin
          if (bus.req_valid == 2'b11) grant = prio ? 2'b10 : 2'b01;
          else                        grant = bus.req_valid;
        end
        if (clear_start) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign bus.req_ready = grant;
  assign busy          = (state == CLEAR);
  assign sram_oeb      = (state != RUN);

  assign issue       = |grant;
  assign issue_port  = grant[1];
  assign issue_we    = issue_port ? bus.req_we[1] : bus.req_we[0];
  assign issue_addr  = issue_port ? bus.req_addr1 : bus.req_addr0;
  assign issue_wdata = issue_port ? bus.req_wdata1 : bus.req_wdata0;

  // Stage p0: macro pin registers; the macro samples them at the end of this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_csb <= 1'b1;
      sram_web <= 1'b1;
      sram_a   <= '0;
      sram_i   <= '0;
      vld_p0   <= 1'b0;
      prio     <= 1'b0;
    end else if (state == CLEAR) begin
      sram_csb <= 1'b0;
      sram_web <= 1'b0;
      sram_a   <= clr_cnt;
      sram_i   <= '0;
      vld_p0   <= 1'b0;
    end else if (issue) begin
      sram_csb <= 1'b0;
      sram_web <= !issue_we;
      sram_a   <= issue_addr;
      sram_i   <= issue_we ? issue_wdata : '0;
      vld_p0   <= 1'b1;
      prio     <= !issue_port;
    end else begin
      sram_csb <= 1'b1;
      sram_web <= 1'b1;
      vld_p0   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    port_p0 <= issue_port;
    rd_p0   <= !issue_we;
    port_p1 <= port_p0;
    rd_p1   <= rd_p0;
  end

  // Stage p1: macro drives sram_o; stage p2: registered completion to the requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      bus.rsp_valid <= 2'b00;
      bus.rsp_rdata <= '0;
    end else begin
      vld_p1        <= vld_p0;
      bus.rsp_valid <= vld_p1 ? (port_p1 ? 2'b10 : 2'b01) : 2'b00;
      bus.rsp_rdata <= (vld_p1 && rd_p1) ? sram_o : '0;
    end
  end
endmodule
